// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD timer controller and its digit counters.
package bcd_timer_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Saturate a nibble into the legal BCD range.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Per-digit value that marks terminal count: 9 counting up, 0 counting down.
  function automatic logic [BCD_W-1:0] term_digit(input logic up);
    return up ? BCD_MAX : 4'd0;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single mod-10 digit: load has priority over enable, up selects direction.
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] q
);

  logic [BCD_W-1:0] q_d, q_q;

  // Next digit value: load, else wrap-around increment/decrement when enabled.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      if (up) begin
        q_d = (q_q >= BCD_MAX) ? 4'd0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// BCD timer sequencer: FSM, prescaler, digit cascade and terminal detect.
// Optional build macro BCD_TIMER_AUTORELOAD_EN: reload PRESET on terminal and keep running.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 10
) (
  input  logic                CLK,
  input  logic                RESET_B,
  input  logic                START,
  input  logic                STOP,
  input  logic                CLEAR,
  input  logic                MODE_UP,
  input  logic [4*DIGITS-1:0] PRESET,
  output logic [4*DIGITS-1:0] COUNT,
  output logic                BUSY,
  output logic                DONE_P,
  output logic [1:0]          STATE
);

  localparam int unsigned CW = BCD_W * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          mode_q, mode_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic              tick_c, run_en_c, load_c, at_term_c, pre_term_c, carry_c;
  logic [CW-1:0]     load_val_c, preset_clamped_c, count_w;
  logic [DIGITS-1:0] en_c;

  assign tick_c = (state_q == ST_RUN) && (pre_q == PRE_LAST);

  // Terminal detect, one-tick-before-terminal detect, clamped preset and carry/borrow chain.
  always_comb begin
    at_term_c        = 1'b1;
    pre_term_c       = 1'b1;
    preset_clamped_c = '0;
    en_c             = '0;
    carry_c          = tick_c & run_en_c;
    for (int i = 0; i < int'(DIGITS); i++) begin
      preset_clamped_c[BCD_W*i +: BCD_W] = bcd_clamp(PRESET[BCD_W*i +: BCD_W]);
      if (count_w[BCD_W*i +: BCD_W] != term_digit(mode_q)) at_term_c = 1'b0;
      if (i == 0) begin
        if (count_w[BCD_W-1:0] != (mode_q ? 4'd8 : 4'd1)) pre_term_c = 1'b0;
      end else if (count_w[BCD_W*i +: BCD_W] != term_digit(mode_q)) begin
        pre_term_c = 1'b0;
      end
      en_c[i] = carry_c;
      carry_c = carry_c & (count_w[BCD_W*i +: BCD_W] == term_digit(mode_q));
    end
  end

  // Next-state, prescaler, load control and registered-output decode.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    load_c     = 1'b0;
    load_val_c = '0;
    run_en_c   = 1'b0;
    if (CLEAR) begin
      load_c  = 1'b1;
      pre_d   = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            load_c     = 1'b1;
            load_val_c = preset_clamped_c;
            pre_d      = '0;
            mode_d     = MODE_UP;
            state_d    = ST_RUN;
          end
        end
        ST_RUN: begin
          if (STOP) begin
            state_d = ST_PAUSE;
          end else begin
            run_en_c = ~at_term_c;
            pre_d    = tick_c ? '0 : pre_q + PW'(1);
            if (at_term_c || (tick_c && pre_term_c)) begin
              done_d = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
              load_c     = 1'b1;
              load_val_c = preset_clamped_c;
              pre_d      = '0;
              mode_d     = MODE_UP;
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
        ST_PAUSE: begin
          if (START) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  // Controller registers.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // One counter per BCD digit, all sharing load and direction.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (CLK),
      .rst_n    (RESET_B),
      .load     (load_c),
      .en       (en_c[g]),
      .up       (mode_q),
      .load_val (load_val_c[BCD_W*g +: BCD_W]),
      .q        (count_w[BCD_W*g +: BCD_W])
    );
  end

  assign COUNT  = count_w;
  assign BUSY   = busy_q;
  assign DONE_P = done_q;
  assign STATE  = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl (DIGITS=2, PRESCALE=4) with an integer reference model.
module tb_bcd_timer_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;
  localparam int MODV     = 100;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, mode_up = 1'b0;
  logic [7:0] preset = 8'h00;
  logic [7:0] count;
  logic       busy, done_p;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  // reference model: timer value as a plain integer 0..99
  int m_val, m_ph, m_st;
  bit m_up, m_done;
  int r;

  always #5 clk = ~clk;

  bcd_timer_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .CLK(clk), .RESET_B(rst_n), .START(start), .STOP(stop), .CLEAR(clear),
    .MODE_UP(mode_up), .PRESET(preset), .COUNT(count), .BUSY(busy),
    .DONE_P(done_p), .STATE(state)
  );

  function automatic int clamp_val(input logic [7:0] p);
    int t, o;
    t = (int'(p[7:4]) > 9) ? 9 : int'(p[7:4]);
    o = (int'(p[3:0]) > 9) ? 9 : int'(p[3:0]);
    return t * 10 + o;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_ph = 0; m_st = S_IDLE; m_up = 1'b0; m_done = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_step();
    int term;
    m_done = 1'b0;
    if (clear) begin
      m_val = 0; m_ph = 0; m_st = S_IDLE;
    end else begin
      case (m_st)
        S_IDLE, S_DONE: if (start) begin
          m_val = clamp_val(preset); m_ph = 0; m_up = mode_up; m_st = S_RUN;
        end
        S_RUN: if (stop) begin
          m_st = S_PAUSE;
        end else begin
          term = m_up ? MODV - 1 : 0;
          if (m_val != term && m_ph == PRESCALE - 1)
            m_val = m_up ? (m_val + 1) % MODV : (m_val + MODV - 1) % MODV;
          m_ph = (m_ph + 1) % PRESCALE;
          if (m_val == term) begin
            m_done = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
            m_val = clamp_val(preset); m_ph = 0; m_up = mode_up;
`else
            m_st = S_DONE;
`endif
          end
        end
        S_PAUSE: if (start) m_st = S_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, count, to_bcd(m_val));
    chk({tag, ".busy"}, 8'(busy), 8'(m_st == S_RUN || m_st == S_PAUSE));
    chk({tag, ".done"}, 8'(done_p), 8'(m_done));
    chk({tag, ".state"}, 8'(state), 8'(m_st));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1; step("clr"); clear = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic up, input string tag);
    preset = p; mode_up = up; start = 1'b1;
    step(tag);
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk_model("reset");
    chk("reset.count_const", count, 8'h00);
    rst_n = 1'b1;

    // down count 12 -> 00
    load(8'h12, 1'b0, "t1_load");
    chk("t1.k", count, 8'h12);
    idle(4, "t1");
    chk("t1.k4", count, 8'h11);
    idle(44, "t1");
    chk("t1.k48", count, 8'h00);
    chk("t1.done", 8'(done_p), 8'h01);
`ifndef BCD_TIMER_AUTORELOAD_EN
    chk("t1.state", 8'(state), 8'(S_DONE));
    idle(1, "t1_hold");
    chk("t1.done_once", 8'(done_p), 8'h00);
`endif

    // cascade in both directions
    do_clear();
    load(8'h09, 1'b1, "t2a_load"); idle(4, "t2a");
    chk("t2a.carry", count, 8'h10);
    do_clear();
    load(8'h98, 1'b1, "t2b_load"); idle(4, "t2b");
    chk("t2b.count", count, 8'h99);
    chk("t2b.done", 8'(done_p), 8'h01);
    do_clear();
    load(8'h10, 1'b0, "t2c_load"); idle(4, "t2c");
    chk("t2c.borrow", count, 8'h09);

    // pause and resume with prescaler phase preserved
    do_clear();
    load(8'h12, 1'b0, "t3_load"); idle(6, "t3");
    stop = 1'b1; step("t3_stop"); stop = 1'b0;
    chk("t3.frozen", count, 8'h11);
    chk("t3.busy", 8'(busy), 8'h01);
    chk("t3.paused", 8'(state), 8'(S_PAUSE));
    idle(5, "t3_pause");
    chk("t3.still", count, 8'h11);
    start = 1'b1; step("t3_resume"); start = 1'b0;
    idle(1, "t3");
    chk("t3.j1", count, 8'h11);
    idle(1, "t3");
    chk("t3.j2", count, 8'h10);

    // clear beats start; clamp; already-terminal preset
    idle(3, "t4_pre");
    clear = 1'b1; start = 1'b1; step("t4_clr"); clear = 1'b0; start = 1'b0;
    chk("t4.state", 8'(state), 8'(S_IDLE));
    chk("t4.count", count, 8'h00);
    chk("t4.done", 8'(done_p), 8'h00);
    load(8'hA5, 1'b0, "t4b_load");
    chk("t4b.clamp", count, 8'h95);
    do_clear();
    load(8'h00, 1'b0, "t4c_load");
    chk("t4c.k_done", 8'(done_p), 8'h00);
    idle(1, "t4c");
    chk("t4c.k1_done", 8'(done_p), 8'h01);
`ifndef BCD_TIMER_AUTORELOAD_EN
    chk("t4c.state", 8'(state), 8'(S_DONE));
`endif

    // asynchronous reset between edges
    do_clear();
    load(8'h50, 1'b0, "t5_load"); idle(5, "t5");
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("t5.count", count, 8'h00);
    chk("t5.busy", 8'(busy), 8'h00);
    chk("t5.state", 8'(state), 8'(S_IDLE));
    @(posedge clk); #1;
    chk_model("t5_held");
    rst_n = 1'b1;

`ifdef BCD_TIMER_AUTORELOAD_EN
    load(8'h02, 1'b0, "t6_load");
    for (int c = 1; c <= 16; c++) begin
      step("t6");
      if (c % 8 == 0) begin
        chk("t6.done", 8'(done_p), 8'h01);
        chk("t6.reload", count, 8'h02);
        chk("t6.state", 8'(state), 8'(S_RUN));
      end else if (c % 8 == 4) begin
        chk("t6.mid", count, 8'h01);
      end
    end
`endif

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      clear   = (r < 2);
      stop    = (r >= 2 && r < 8);
      start   = (r >= 8 && r < 20);
      mode_up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        preset = {($urandom_range(0, 1) == 1) ? 4'd9 : 4'd0, 4'($urandom_range(0, 15))};
      else
        preset = 8'($urandom);
      step("rand");
    end
    clear = 1'b0; stop = 1'b0; start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
